mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage_if.sv | 20 ++
 rtl/mem_stage.sv | 203 ++++++++++++++++++++
 tb/tb_mem_stage.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_if.sv
// Memory bus between the MEM stage and the data RAM.
// The stage raises mem_req with stable address/data until the RAM answers with mem_ack.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage.
// ALU ops and misaligned memory ops pass straight through with one cycle of latency.
// Aligned loads and stores are captured, held on the RAM bus until mem_ack, and then retired.
module mem_stage (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [31:0]        in_pc_data,
    input  logic [31:0]        in_rs2_data,
    input  logic [4:0]         in_rd_address,
    input  logic [31:0]        in_alu_rd_result,
    input  logic               in_alu_rd_result_is_zero,
    input  logic [31:0]        in_alu_pc_result,
    input  logic [1:0]         in_next_pc_src,
    input  logic               in_reg_write_data_src,
    input  logic               in_reg_wren,
    input  logic               in_ram_wren,
    output logic               stall,
    mem_stage_if.master        mem,
    output logic               out_valid,
    output logic [31:0]        out_pc_data,
    output logic [4:0]         out_rd_address,
    output logic               out_reg_wren,
    output logic [31:0]        out_write_data,
    output logic               pc_redirect,
    output logic [31:0]        out_pc_target,
    output logic               misaligned_fault
);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t      state_q, state_d;
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_data_q, out_pc_data_d;
    logic [4:0]  out_rd_address_q, out_rd_address_d;
    logic        out_reg_wren_q, out_reg_wren_d;
    logic [31:0] out_write_data_q, out_write_data_d;
    logic        pc_redirect_q, pc_redirect_d;
    logic [31:0] out_pc_target_q, out_pc_target_d;
    logic        misaligned_fault_q, misaligned_fault_d;

    // Fields of the in-flight memory op, retired when the RAM acknowledges.
    logic [31:0] cap_pc_q, cap_pc_d;
    logic [4:0]  cap_rd_q, cap_rd_d;
    logic        cap_reg_wren_q, cap_reg_wren_d;
    logic        cap_load_q, cap_load_d;
    logic [31:0] cap_alu_q, cap_alu_d;
    logic        cap_is_zero_q, cap_is_zero_d;
    logic [31:0] cap_pc_tgt_q, cap_pc_tgt_d;
    logic [1:0]  cap_pc_src_q, cap_pc_src_d;

    logic mem_op;
    logic aligned;

    // 2'b10 is an unconditional jump, 2'b01 a branch taken on a zero compare.
    function automatic logic branch_taken(input logic [1:0] src, input logic is_zero);
        return (src == 2'b10) || ((src == 2'b01) && is_zero);
    endfunction

    assign mem_op  = in_valid && (in_reg_write_data_src || in_ram_wren);
    assign aligned = (in_alu_rd_result[1:0] == 2'b00);

    // Next-state, stall and output computation for both FSM states.
    always_comb begin
        state_d            = state_q;
        mem_req_d          = mem_req_q;
        mem_we_d           = mem_we_q;
        mem_addr_d         = mem_addr_q;
        mem_wdata_d        = mem_wdata_q;
        out_valid_d        = 1'b0;
        out_pc_data_d      = out_pc_data_q;
        out_rd_address_d   = out_rd_address_q;
        out_reg_wren_d     = 1'b0;
        out_write_data_d   = out_write_data_q;
        pc_redirect_d      = 1'b0;
        out_pc_target_d    = out_pc_target_q;
        misaligned_fault_d = 1'b0;
        cap_pc_d           = cap_pc_q;
        cap_rd_d           = cap_rd_q;
        cap_reg_wren_d     = cap_reg_wren_q;
        cap_load_d         = cap_load_q;
        cap_alu_d          = cap_alu_q;
        cap_is_zero_d      = cap_is_zero_q;
        cap_pc_tgt_d       = cap_pc_tgt_q;
        cap_pc_src_d       = cap_pc_src_q;
        stall              = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (mem_op && aligned) begin
                    stall          = 1'b1;
                    state_d        = BUSY;
                    mem_req_d      = 1'b1;
                    mem_we_d       = in_ram_wren;
                    mem_addr_d     = in_alu_rd_result;
                    mem_wdata_d    = in_rs2_data;
                    cap_pc_d       = in_pc_data;
                    cap_rd_d       = in_rd_address;
                    cap_reg_wren_d = in_reg_wren;
                    cap_load_d     = in_reg_write_data_src;
                    cap_alu_d      = in_alu_rd_result;
                    cap_is_zero_d  = in_alu_rd_result_is_zero;
                    cap_pc_tgt_d   = in_alu_pc_result;
                    cap_pc_src_d   = in_next_pc_src;
                end else begin
                    // ALU op, misaligned memory op (faulted, never reaches RAM) or bubble.
                    out_valid_d        = in_valid;
                    misaligned_fault_d = mem_op;
                    out_pc_data_d      = in_pc_data;
                    out_rd_address_d   = in_rd_address;
                    out_write_data_d   = in_alu_rd_result;
                    out_pc_target_d    = in_alu_pc_result;
                    out_reg_wren_d     = in_valid && !mem_op && in_reg_wren;
                    pc_redirect_d      = in_valid && !mem_op &&
                                         branch_taken(in_next_pc_src, in_alu_rd_result_is_zero);
                end
            end
            BUSY: begin
                stall = !mem.mem_ack;
                if (mem.mem_ack) begin
                    state_d          = IDLE;
                    mem_req_d        = 1'b0;
                    out_valid_d      = 1'b1;
                    out_pc_data_d    = cap_pc_q;
                    out_rd_address_d = cap_rd_q;
                    out_write_data_d = cap_load_q ? mem.mem_rdata : cap_alu_q;
                    out_pc_target_d  = cap_pc_tgt_q;
                    out_reg_wren_d   = cap_reg_wren_q;
                    pc_redirect_d    = branch_taken(cap_pc_src_q, cap_is_zero_q);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset clears everything and abandons any pending access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            mem_req_q          <= 1'b0;
            mem_we_q           <= 1'b0;
            mem_addr_q         <= '0;
            mem_wdata_q        <= '0;
            out_valid_q        <= 1'b0;
            out_pc_data_q      <= '0;
            out_rd_address_q   <= '0;
            out_reg_wren_q     <= 1'b0;
            out_write_data_q   <= '0;
            pc_redirect_q      <= 1'b0;
            out_pc_target_q    <= '0;
            misaligned_fault_q <= 1'b0;
            cap_pc_q           <= '0;
            cap_rd_q           <= '0;
            cap_reg_wren_q     <= 1'b0;
            cap_load_q         <= 1'b0;
            cap_alu_q          <= '0;
            cap_is_zero_q      <= 1'b0;
            cap_pc_tgt_q       <= '0;
            cap_pc_src_q       <= '0;
        end else begin
            state_q            <= state_d;
            mem_req_q          <= mem_req_d;
            mem_we_q           <= mem_we_d;
            mem_addr_q         <= mem_addr_d;
            mem_wdata_q        <= mem_wdata_d;
            out_valid_q        <= out_valid_d;
            out_pc_data_q      <= out_pc_data_d;
            out_rd_address_q   <= out_rd_address_d;
            out_reg_wren_q     <= out_reg_wren_d;
            out_write_data_q   <= out_write_data_d;
            pc_redirect_q      <= pc_redirect_d;
            out_pc_target_q    <= out_pc_target_d;
            misaligned_fault_q <= misaligned_fault_d;
            cap_pc_q           <= cap_pc_d;
            cap_rd_q           <= cap_rd_d;
            cap_reg_wren_q     <= cap_reg_wren_d;
            cap_load_q         <= cap_load_d;
            cap_alu_q          <= cap_alu_d;
            cap_is_zero_q      <= cap_is_zero_d;
            cap_pc_tgt_q       <= cap_pc_tgt_d;
            cap_pc_src_q       <= cap_pc_src_d;
        end
    end

    assign mem.mem_req       = mem_req_q;
    assign mem.mem_we        = mem_we_q;
    assign mem.mem_addr      = mem_addr_q;
    assign mem.mem_wdata     = mem_wdata_q;
    assign out_valid         = out_valid_q;
    assign out_pc_data       = out_pc_data_q;
    assign out_rd_address    = out_rd_address_q;
    assign out_reg_wren      = out_reg_wren_q;
    assign out_write_data    = out_write_data_q;
    assign pc_redirect       = pc_redirect_q;
    assign out_pc_target     = out_pc_target_q;
    assign misaligned_fault  = misaligned_fault_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a vector table of single-cycle ops plus
// hand-written load, store and reset-during-access sequences.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_pc_data;
    logic [31:0] in_rs2_data;
    logic [4:0]  in_rd_address;
    logic [31:0] in_alu_rd_result;
    logic        in_alu_rd_result_is_zero;
    logic [31:0] in_alu_pc_result;
    logic [1:0]  in_next_pc_src;
    logic        in_reg_write_data_src;
    logic        in_reg_wren;
    logic        in_ram_wren;
    logic        stall;
    logic        out_valid;
    logic [31:0] out_pc_data;
    logic [4:0]  out_rd_address;
    logic        out_reg_wren;
    logic [31:0] out_write_data;
    logic        pc_redirect;
    logic [31:0] out_pc_target;
    logic        misaligned_fault;

    int checks = 0;
    int errors = 0;

    mem_stage_if mif ();

    mem_stage dut (
        .clk                      (clk),
        .reset                    (reset),
        .in_valid                 (in_valid),
        .in_pc_data               (in_pc_data),
        .in_rs2_data              (in_rs2_data),
        .in_rd_address            (in_rd_address),
        .in_alu_rd_result         (in_alu_rd_result),
        .in_alu_rd_result_is_zero (in_alu_rd_result_is_zero),
        .in_alu_pc_result         (in_alu_pc_result),
        .in_next_pc_src           (in_next_pc_src),
        .in_reg_write_data_src    (in_reg_write_data_src),
        .in_reg_wren              (in_reg_wren),
        .in_ram_wren              (in_ram_wren),
        .stall                    (stall),
        .mem                      (mif.master),
        .out_valid                (out_valid),
        .out_pc_data              (out_pc_data),
        .out_rd_address           (out_rd_address),
        .out_reg_wren             (out_reg_wren),
        .out_write_data           (out_write_data),
        .pc_redirect              (pc_redirect),
        .out_pc_target            (out_pc_target),
        .misaligned_fault         (misaligned_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] alu;
        logic        zero;
        logic [31:0] tgt;
        logic [1:0]  src;
        logic        wds;
        logic        rwren;
        logic        ramw;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        e_ov;
        logic        e_wren;
        logic        e_redir;
        logic        e_fault;
        logic        chk_data;
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        in_valid                 = 1'b0;
        in_pc_data               = '0;
        in_rs2_data              = '0;
        in_rd_address            = '0;
        in_alu_rd_result         = '0;
        in_alu_rd_result_is_zero = 1'b0;
        in_alu_pc_result         = '0;
        in_next_pc_src           = 2'b00;
        in_reg_write_data_src    = 1'b0;
        in_reg_wren              = 1'b0;
        in_ram_wren              = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall"}, {31'b0, stall}, 32'h0);
        check({tag, "_mem_req"}, {31'b0, mif.mem_req}, 32'h0);
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'h0);
        check({tag, "_redirect"}, {31'b0, pc_redirect}, 32'h0);
        check({tag, "_fault"}, {31'b0, misaligned_fault}, 32'h0);
        check({tag, "_reg_wren"}, {31'b0, out_reg_wren}, 32'h0);
        check({tag, "_write_data"}, out_write_data, 32'h0);
        check({tag, "_mem_addr"}, mif.mem_addr, 32'h0);
        check({tag, "_mem_we"}, {31'b0, mif.mem_we}, 32'h0);
        check({tag, "_pc_target"}, out_pc_target, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int stall_cycles;

        vt[0] = '{1'b1, 32'h10,  1'b0, 32'h0,   2'b00, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[1] = '{1'b1, 32'h20,  1'b1, 32'h400, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1004, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vt[2] = '{1'b1, 32'h20,  1'b0, 32'h400, 2'b01, 1'b0, 1'b0, 1'b0, 5'd0, 32'h1008, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 32'h44,  1'b0, 32'h800, 2'b10, 1'b0, 1'b1, 1'b0, 5'd1, 32'h100C, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        vt[4] = '{1'b1, 32'h0,   1'b1, 32'h900, 2'b11, 1'b0, 1'b1, 1'b0, 5'd2, 32'h1010, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[5] = '{1'b1, 32'h102, 1'b0, 32'h500, 2'b10, 1'b1, 1'b1, 1'b0, 5'd3, 32'h1014, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[6] = '{1'b1, 32'h203, 1'b0, 32'h0,   2'b00, 1'b0, 1'b0, 1'b1, 5'd0, 32'h1018, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[7] = '{1'b0, 32'h55,  1'b1, 32'h600, 2'b10, 1'b0, 1'b1, 1'b0, 5'd4, 32'h101C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

        clear_inputs();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        reset = 1'b1;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Single-cycle ops applied back to back; each retires on the next edge.
        for (int i = 0; i < 8; i++) begin
            in_valid                 = vt[i].valid;
            in_alu_rd_result         = vt[i].alu;
            in_alu_rd_result_is_zero = vt[i].zero;
            in_alu_pc_result         = vt[i].tgt;
            in_next_pc_src           = vt[i].src;
            in_reg_write_data_src    = vt[i].wds;
            in_reg_wren              = vt[i].rwren;
            in_ram_wren              = vt[i].ramw;
            in_rd_address            = vt[i].rd;
            in_pc_data               = vt[i].pc;
            in_rs2_data              = 32'hCAFE0000 + i;
            #1;
            check($sformatf("v%0d_stall", i), {31'b0, stall}, 32'h0);
            tick();
            check($sformatf("v%0d_mem_req", i), {31'b0, mif.mem_req}, 32'h0);
            check($sformatf("v%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vt[i].e_ov});
            check($sformatf("v%0d_reg_wren", i), {31'b0, out_reg_wren}, {31'b0, vt[i].e_wren});
            check($sformatf("v%0d_redirect", i), {31'b0, pc_redirect}, {31'b0, vt[i].e_redir});
            check($sformatf("v%0d_fault", i), {31'b0, misaligned_fault}, {31'b0, vt[i].e_fault});
            if (vt[i].chk_data) begin
                check($sformatf("v%0d_write_data", i), out_write_data, vt[i].alu);
                check($sformatf("v%0d_rd", i), {27'b0, out_rd_address}, {27'b0, vt[i].rd});
                check($sformatf("v%0d_pc", i), out_pc_data, vt[i].pc);
                check($sformatf("v%0d_target", i), out_pc_target, vt[i].tgt);
            end
        end
        clear_inputs();
        tick();

        // mem_ack in IDLE must not create a result.
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'h12345678;
        #1;
        check("idle_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        mif.mem_ack = 1'b0;
        check("idle_ack_out_valid", {31'b0, out_valid}, 32'h0);
        check("idle_ack_mem_req", {31'b0, mif.mem_req}, 32'h0);

        // Load from 0x100 acknowledged three cycles after the request.
        stall_cycles          = 0;
        in_valid              = 1'b1;
        in_alu_rd_result      = 32'h100;
        in_reg_write_data_src = 1'b1;
        in_reg_wren           = 1'b1;
        in_rd_address         = 5'd7;
        in_pc_data            = 32'h2000;
        #1;
        if (stall) stall_cycles++;
        tick();
        in_alu_rd_result = 32'hFFFF_FFF0;
        in_rs2_data      = 32'hBAD0BAD0;
        in_ram_wren      = 1'b1;
        for (int c = 0; c < 3; c++) begin
            check($sformatf("ld_mem_req_c%0d", c), {31'b0, mif.mem_req}, 32'h1);
            check($sformatf("ld_mem_addr_c%0d", c), mif.mem_addr, 32'h100);
            check($sformatf("ld_mem_we_c%0d", c), {31'b0, mif.mem_we}, 32'h0);
            check($sformatf("ld_out_valid_c%0d", c), {31'b0, out_valid}, 32'h0);
            if (stall) stall_cycles++;
            tick();
        end
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hDEADBEEF;
        #1;
        check("ld_ack_mem_req", {31'b0, mif.mem_req}, 32'h1);
        check("ld_ack_stall", {31'b0, stall}, 32'h0);
        check("ld_stall_cycles", stall_cycles, 32'd4);
        tick();
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = '0;
        clear_inputs();
        check("ld_out_valid", {31'b0, out_valid}, 32'h1);
        check("ld_write_data", out_write_data, 32'hDEADBEEF);
        check("ld_rd", {27'b0, out_rd_address}, 32'd7);
        check("ld_pc", out_pc_data, 32'h2000);
        check("ld_reg_wren", {31'b0, out_reg_wren}, 32'h1);
        check("ld_mem_req_done", {31'b0, mif.mem_req}, 32'h0);
        tick();
        check("ld_out_valid_pulse", {31'b0, out_valid}, 32'h0);

        // Store to 0x204 with an immediate acknowledge.
        in_valid         = 1'b1;
        in_alu_rd_result = 32'h204;
        in_rs2_data      = 32'h1234;
        in_ram_wren      = 1'b1;
        in_rd_address    = 5'd9;
        #1;
        check("st_accept_stall", {31'b0, stall}, 32'h1);
        tick();
        clear_inputs();
        check("st_mem_req", {31'b0, mif.mem_req}, 32'h1);
        check("st_mem_we", {31'b0, mif.mem_we}, 32'h1);
        check("st_mem_wdata", mif.mem_wdata, 32'h1234);
        check("st_mem_addr", mif.mem_addr, 32'h204);
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'h77777777;
        #1;
        check("st_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        mif.mem_ack = 1'b0;
        check("st_out_valid", {31'b0, out_valid}, 32'h1);
        check("st_reg_wren", {31'b0, out_reg_wren}, 32'h0);
        check("st_write_data", out_write_data, 32'h204);
        check("st_fault", {31'b0, misaligned_fault}, 32'h0);

        // Reset during an outstanding load, then a late acknowledge.
        in_valid              = 1'b1;
        in_alu_rd_result      = 32'h300;
        in_reg_write_data_src = 1'b1;
        in_reg_wren           = 1'b1;
        in_alu_pc_result      = 32'h440;
        in_next_pc_src        = 2'b10;
        tick();
        clear_inputs();
        check("rst_busy_mem_req", {31'b0, mif.mem_req}, 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_all_zero("rst_busy");
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = 32'hAAAA5555;
        #1;
        check("rst_late_ack_stall", {31'b0, stall}, 32'h0);
        tick();
        mif.mem_ack = 1'b0;
        check("rst_late_ack_out_valid", {31'b0, out_valid}, 32'h0);
        check("rst_late_ack_write_data", out_write_data, 32'h0);

        // Back in IDLE: an ALU op retires after one cycle.
        in_valid         = 1'b1;
        in_alu_rd_result = 32'h99;
        in_reg_wren      = 1'b1;
        in_rd_address    = 5'd11;
        #1;
        check("post_rst_stall", {31'b0, stall}, 32'h0);
        tick();
        clear_inputs();
        check("post_rst_out_valid", {31'b0, out_valid}, 32'h1);
        check("post_rst_write_data", out_write_data, 32'h99);
        check("post_rst_reg_wren", {31'b0, out_reg_wren}, 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
